// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: F/EX/WB control for the RV32 core with multiply stalls, WB gating, forwarding and retire count
module pipeline_sequencer #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ex_itype,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_gpio_we,
  input  logic        ex_is_mul,
  output logic        pc_en,
  output logic        ex_valid,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        regfile_we,
  output logic        gpio_we_q,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [31:0] instret
);
  typedef enum logic [1:0] {BOOT, RUN, MUL_WAIT} state_t;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;
  logic        wb_valid_q, wb_regwrite_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] instret_q;
  // next state, PC advance and WB capture decision for the instruction in EX
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_en    = 1'b0;
    ex_valid = 1'b0;
    busy     = 1'b0;
    capture  = 1'b0;
    case (state_q)
      BOOT: begin
        pc_en   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        ex_valid = 1'b1;
        if (ex_is_mul && MUL_LAT > 1) begin
          cnt_d   = MUL_CNT;
          state_d = MUL_WAIT;
        end else begin
          pc_en   = 1'b1;
          capture = 1'b1;
        end
      end
      MUL_WAIT: begin
        ex_valid = 1'b1;
        busy     = 1'b1;
        if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
        else begin
          pc_en   = 1'b1;
          capture = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end
  // state, WB register and retire counter; a non-capture edge leaves a bubble in WB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      cnt_q         <= 4'd0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      gpio_we_q     <= 1'b0;
      instret_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_valid_q    <= capture;
      wb_regwrite_q <= capture & ex_regwrite;
      gpio_we_q     <= capture & ex_gpio_we;
      if (capture) wb_rd_q <= ex_rd;
      if (wb_valid_q) instret_q <= instret_q + 32'd1;
    end
  end
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_regwrite_q;
  assign instret     = instret_q;
  assign regfile_we  = wb_valid_q & wb_regwrite_q & (wb_rd_q != 5'd0);
  assign fwd_a = regfile_we & ex_valid & (ex_itype != 3'b010) & (wb_rd_q == ex_rs1);
  assign fwd_b = regfile_we & ex_valid & (ex_itype == 3'b000) & (wb_rd_q == ex_rs2);
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: three lanes (MUL_LAT 1/3/4) checked every cycle against an occupancy model plus directed literals
module tb_pipeline_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ex_itype = 3'd1;
  logic [4:0]  ex_rs1 = 5'd0, ex_rs2 = 5'd0, ex_rd = 5'd0;
  logic        ex_regwrite = 1'b0, ex_gpio_we = 1'b0, ex_is_mul = 1'b0;
  logic [2:0]  pc_en_v, ex_valid_v, busy_v, wb_valid_v, wb_regwrite_v, regfile_we_v, gpio_v, fwd_a_v, fwd_b_v;
  logic [4:0]  wb_rd_v [3];
  logic [31:0] instret_v [3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  function automatic int lat(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    pipeline_sequencer #(.MUL_LAT((g == 0) ? 1 : (g == 1) ? 3 : 4)) dut (
      .clk(clk), .rst_n(rst_n), .ex_itype(ex_itype), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_gpio_we(ex_gpio_we), .ex_is_mul(ex_is_mul),
      .pc_en(pc_en_v[g]), .ex_valid(ex_valid_v[g]), .busy(busy_v[g]), .wb_valid(wb_valid_v[g]),
      .wb_rd(wb_rd_v[g]), .wb_regwrite(wb_regwrite_v[g]), .regfile_we(regfile_we_v[g]),
      .gpio_we_q(gpio_v[g]), .fwd_a(fwd_a_v[g]), .fwd_b(fwd_b_v[g]), .instret(instret_v[g])
    );
  end

  // model: EX either empty (after reset) or holds an instruction of a known age and occupancy
  logic        seen_rst = 1'b0;
  logic [2:0]  m_empty = 3'b111, m_wbv = 3'b0, m_wbrw = 3'b0, m_gpio = 3'b0;
  int          m_age [3] = '{0, 0, 0};
  int          m_occ [3] = '{1, 1, 1};
  logic [4:0]  m_wbrd [3] = '{5'd0, 5'd0, 5'd0};
  logic [31:0] m_inst [3] = '{32'd0, 32'd0, 32'd0};
  logic [2:0]  e_exv, e_leave, e_pc, e_busy, e_rfwe, e_fa, e_fb;
  int          e_occ [3];

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      e_exv[g]   = !m_empty[g];
      e_occ[g]   = (m_age[g] == 0) ? (ex_is_mul ? lat(g) : 1) : m_occ[g];
      e_leave[g] = e_exv[g] && (m_age[g] + 1 >= e_occ[g]);
      e_pc[g]    = !e_exv[g] || e_leave[g];
      e_busy[g]  = e_exv[g] && (m_age[g] > 0);
      e_rfwe[g]  = m_wbv[g] && m_wbrw[g] && (m_wbrd[g] != 5'd0);
      e_fa[g]    = e_rfwe[g] && e_exv[g] && (ex_itype != 3'b010) && (m_wbrd[g] == ex_rs1);
      e_fb[g]    = e_rfwe[g] && e_exv[g] && (ex_itype == 3'b000) && (m_wbrd[g] == ex_rs2);
    end
  end

  always @(posedge clk) begin
    seen_rst <= seen_rst | !rst_n;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        m_empty[g] <= 1'b1; m_age[g] <= 0; m_wbv[g] <= 1'b0; m_wbrw[g] <= 1'b0;
        m_gpio[g] <= 1'b0; m_wbrd[g] <= 5'd0; m_inst[g] <= 32'd0;
      end else begin
        m_inst[g]  <= m_inst[g] + {31'd0, m_wbv[g]};
        m_empty[g] <= 1'b0;
        m_wbv[g]   <= e_leave[g];
        m_wbrw[g]  <= e_leave[g] & ex_regwrite;
        m_gpio[g]  <= e_leave[g] & ex_gpio_we;
        if (e_leave[g]) m_wbrd[g] <= ex_rd;
        if (!e_exv[g] || e_leave[g]) m_age[g] <= 0;
        else begin
          m_age[g] <= m_age[g] + 1;
          m_occ[g] <= e_occ[g];
        end
      end
    end
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (seen_rst) begin
      for (int g = 0; g < 3; g++) begin
        chk("pc_en", g, 32'(pc_en_v[g]), 32'(e_pc[g]));
        chk("ex_valid", g, 32'(ex_valid_v[g]), 32'(e_exv[g]));
        chk("busy", g, 32'(busy_v[g]), 32'(e_busy[g]));
        chk("wb_valid", g, 32'(wb_valid_v[g]), 32'(m_wbv[g]));
        chk("wb_rd", g, 32'(wb_rd_v[g]), 32'(m_wbrd[g]));
        chk("wb_regwrite", g, 32'(wb_regwrite_v[g]), 32'(m_wbrw[g]));
        chk("regfile_we", g, 32'(regfile_we_v[g]), 32'(e_rfwe[g]));
        chk("gpio_we_q", g, 32'(gpio_v[g]), 32'(m_gpio[g]));
        chk("fwd_a", g, 32'(fwd_a_v[g]), 32'(e_fa[g]));
        chk("fwd_b", g, 32'(fwd_b_v[g]), 32'(e_fb[g]));
        chk("instret", g, instret_v[g], m_inst[g]);
      end
    end
  end

  task automatic drive(input logic r, input logic [2:0] it, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic rw, input logic gw, input logic m);
    @(posedge clk);
    #1;
    rst_n = r; ex_itype = it; ex_rs1 = s1; ex_rs2 = s2; ex_rd = d;
    ex_regwrite = rw; ex_gpio_we = gw; ex_is_mul = m;
    #3;
  endtask

  task automatic nop(input logic r);
    drive(r, 3'b001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset release, forwarding and x0 handling on the single-cycle lane
    nop(1'b0);
    nop(1'b1);
    chk("t1_boot_pc_en", 0, 32'(pc_en_v[0]), 32'd1);
    chk("t1_boot_ex_valid", 0, 32'(ex_valid_v[0]), 32'd0);
    chk("t1_boot_wb_valid", 0, 32'(wb_valid_v[0]), 32'd0);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("t1_ex_valid", 0, 32'(ex_valid_v[0]), 32'd1);
    drive(1'b1, 3'b001, 5'd5, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("t1_wb_valid", 0, 32'(wb_valid_v[0]), 32'd1);
    chk("t2_wb_rd", 0, 32'(wb_rd_v[0]), 32'd5);
    chk("t2_regfile_we", 0, 32'(regfile_we_v[0]), 32'd1);
    chk("t2_fwd_a", 0, 32'(fwd_a_v[0]), 32'd1);
    chk("t2_fwd_b", 0, 32'(fwd_b_v[0]), 32'd0);
    chk("t1_instret0", 0, instret_v[0], 32'd0);
    drive(1'b1, 3'b000, 5'd3, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("t2_sub_fwd_a", 0, 32'(fwd_a_v[0]), 32'd0);
    chk("t2_sub_fwd_b", 0, 32'(fwd_b_v[0]), 32'd1);
    chk("t1_instret1", 0, instret_v[0], 32'd1);
    drive(1'b1, 3'b001, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("t3_instret2", 0, instret_v[0], 32'd2);
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("t3_x0_regfile_we", 0, 32'(regfile_we_v[0]), 32'd0);
    chk("t3_x0_fwd_a", 0, 32'(fwd_a_v[0]), 32'd0);
    chk("t3_x0_fwd_b", 0, 32'(fwd_b_v[0]), 32'd0);
    chk("t3_x0_wb_valid", 0, 32'(wb_valid_v[0]), 32'd1);
    chk("t3_instret3", 0, instret_v[0], 32'd3);
    drive(1'b1, 3'b001, 5'd0, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("t3_instret4", 0, instret_v[0], 32'd4);
    // lui never forwards; csrrw strobes gpio for one cycle without a regfile write
    drive(1'b1, 3'b010, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("t5_lui_wb_rd", 0, 32'(wb_rd_v[0]), 32'd9);
    chk("t5_lui_regfile_we", 0, 32'(regfile_we_v[0]), 32'd1);
    chk("t5_lui_fwd_a", 0, 32'(fwd_a_v[0]), 32'd0);
    drive(1'b1, 3'b001, 5'd9, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0);
    chk("t5_gpio_before", 0, 32'(gpio_v[0]), 32'd0);
    nop(1'b1);
    chk("t5_gpio_strobe", 0, 32'(gpio_v[0]), 32'd1);
    chk("t5_csr_regfile_we", 0, 32'(regfile_we_v[0]), 32'd0);
    nop(1'b1);
    chk("t5_gpio_after", 0, 32'(gpio_v[0]), 32'd0);
    // MUL_LAT=3 multiply occupancy
    nop(1'b0);
    nop(1'b1);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("t4_n_pc_en", 1, 32'(pc_en_v[1]), 32'd0);
    chk("t4_n_busy", 1, 32'(busy_v[1]), 32'd0);
    chk("t4_n_ex_valid", 1, 32'(ex_valid_v[1]), 32'd1);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("t4_n1_pc_en", 1, 32'(pc_en_v[1]), 32'd0);
    chk("t4_n1_busy", 1, 32'(busy_v[1]), 32'd1);
    chk("t4_n1_wb_valid", 1, 32'(wb_valid_v[1]), 32'd0);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("t4_n2_pc_en", 1, 32'(pc_en_v[1]), 32'd1);
    chk("t4_n2_busy", 1, 32'(busy_v[1]), 32'd1);
    chk("t4_n2_wb_valid", 1, 32'(wb_valid_v[1]), 32'd0);
    nop(1'b1);
    chk("t4_n3_wb_valid", 1, 32'(wb_valid_v[1]), 32'd1);
    chk("t4_n3_wb_rd", 1, 32'(wb_rd_v[1]), 32'd8);
    chk("t4_n3_busy", 1, 32'(busy_v[1]), 32'd0);
    nop(1'b1);
    chk("t4_n4_wb_rd", 1, 32'(wb_rd_v[1]), 32'd0);
    // MUL_LAT=4 multiply discarded by a reset mid-stall
    nop(1'b0);
    nop(1'b1);
    drive(1'b1, 3'b001, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("t6_n_instret", 2, instret_v[2], 32'd1);
    drive(1'b1, 3'b000, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    chk("t6_n1_instret", 2, instret_v[2], 32'd2);
    chk("t6_n1_busy", 2, 32'(busy_v[2]), 32'd1);
    drive(1'b0, 3'b000, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    nop(1'b1);
    chk("t6_rst_pc_en", 2, 32'(pc_en_v[2]), 32'd1);
    chk("t6_rst_ex_valid", 2, 32'(ex_valid_v[2]), 32'd0);
    chk("t6_rst_busy", 2, 32'(busy_v[2]), 32'd0);
    chk("t6_rst_instret", 2, instret_v[2], 32'd0);
    chk("t6_rst_wb_valid", 2, 32'(wb_valid_v[2]), 32'd0);
    nop(1'b1);
    chk("t6_after_ex_valid", 2, 32'(ex_valid_v[2]), 32'd1);
    chk("t6_after_wb_valid", 2, 32'(wb_valid_v[2]), 32'd0);
    nop(1'b1);
    chk("t6_nop_wb_rd", 2, 32'(wb_rd_v[2]), 32'd0);
    chk("t6_nop_instret", 2, instret_v[2], 32'd0);
    @(posedge clk);
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
